// File: rtl/uart_rx.sv
// uart_rx: UART receiver for an 8N1 serial link, oversampled by baud_tick.
// Received bytes are delivered through a one-entry valid/ready holding register.
// Framing, overrun and parity errors are reported as one-clock pulses.
// Optional build macro: UART_RX_PARITY_EN (8E1 frame with even parity check;
// without it the frame is 8N1 and rx_parity_err is tied low).
// OVERSAMPLE must be even and >= 4; SYNC_STAGES must be >= 2.
module uart_rx #(
    parameter int OVERSAMPLE  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_parity_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxs_s;
    logic                   rxs_d_r;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       tick_cnt_r;
    logic [CNT_W-1:0]       tick_cnt_nxt_s;
    logic [CNT_W-1:0]       tick_inc_s;
    logic [2:0]             bit_cnt_r;
    logic [2:0]             bit_cnt_nxt_s;
    logic [7:0]             shift_r;
    logic [7:0]             shift_nxt_s;

    logic                   stop_done_s;
    logic                   par_err_s;
    logic                   frame_good_s;

`ifdef UART_RX_PARITY_EN
    logic                   par_err_r;
    logic                   par_err_nxt_s;

    // Even parity: the data bits plus the parity bit must XOR to zero.
    function automatic logic parity_fail(input logic [7:0] data, input logic par_bit);
        return ^{data, par_bit};
    endfunction
`endif

    assign rxs_s      = sync_r[SYNC_STAGES-1];
    assign tick_inc_s = tick_cnt_r + CNT_ONE;

`ifdef UART_RX_PARITY_EN
    assign par_err_s  = par_err_r;
`else
    assign par_err_s  = 1'b0;
`endif

    assign frame_good_s = stop_done_s & rxs_s & ~par_err_s;

    // Metastability synchronizer for the asynchronous line, idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx_serial};
        end
    end

    // One-clock delayed copy of the synchronized line for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxs_d_r <= 1'b1;
        end else begin
            rxs_d_r <= rxs_s;
        end
    end

    // Receiver state, oversample counter, bit counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= CNT_ZERO;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_err_r  <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            tick_cnt_r <= tick_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
`ifdef UART_RX_PARITY_EN
            par_err_r  <= par_err_nxt_s;
`endif
        end
    end

    // Next-state logic: mid-bit sampling of start, data, parity and stop bits.
    always_comb begin
        state_nxt_s    = state_r;
        tick_cnt_nxt_s = tick_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        stop_done_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_nxt_s  = par_err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // Only a 1->0 transition starts a frame, so a held-low line never retriggers.
                if (rxs_d_r && !rxs_s) begin
                    state_nxt_s    = ST_START;
                    tick_cnt_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (tick_inc_s == CNT_HALF) begin
                        tick_cnt_nxt_s = CNT_ZERO;
                        if (rxs_s) begin
                            // Line back high at mid start bit: glitch, not a frame.
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s   = ST_DATA;
                            bit_cnt_nxt_s = 3'd0;
`ifdef UART_RX_PARITY_EN
                            par_err_nxt_s = 1'b0;
`endif
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_inc_s;
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (tick_inc_s == CNT_FULL) begin
                        tick_cnt_nxt_s = CNT_ZERO;
                        // LSB arrives first; after eight shifts it sits in bit 0.
                        shift_nxt_s    = {rxs_s, shift_r[7:1]};
                        bit_cnt_nxt_s  = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt_s = ST_PARITY;
`else
                            state_nxt_s = ST_STOP;
`endif
                        end else begin
                            state_nxt_s = ST_DATA;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_inc_s;
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    if (tick_inc_s == CNT_FULL) begin
                        tick_cnt_nxt_s = CNT_ZERO;
                        par_err_nxt_s  = parity_fail(shift_r, rxs_s);
                        state_nxt_s    = ST_STOP;
                    end else begin
                        tick_cnt_nxt_s = tick_inc_s;
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    if (tick_inc_s == CNT_FULL) begin
                        tick_cnt_nxt_s = CNT_ZERO;
                        stop_done_s    = 1'b1;
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        tick_cnt_nxt_s = tick_inc_s;
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                tick_cnt_nxt_s = CNT_ZERO;
                bit_cnt_nxt_s  = 3'd0;
            end
        endcase
    end

    // Holding register, valid/ready handshake and one-clock error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= stop_done_s & ~rxs_s;
            rx_overrun   <= 1'b0;
            if (frame_good_s) begin
                // A byte accepted on this same clock frees the register for the new one.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_r;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error pulse, aligned with the frame error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_parity_err <= 1'b0;
        end else begin
            rx_parity_err <= stop_done_s & par_err_s;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. baud_tick every 4 clk, 32 clk per bit.
// Honours UART_RX_PARITY_EN when defined for the whole build.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       baud_tick;
    logic       rx_serial;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_parity_err;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int BIT_CLK  = 32;
    localparam int FRAME_CLK = NBITS * BIT_CLK;
    // Clock offset (from the aligned start edge) of the posedge that loads the byte:
    // 3 clk to detect the edge, then 4 ticks to mid start bit, then 8 ticks per bit.
    localparam int LOAD_OFF = 17 + BIT_CLK * (NBITS - 1);

    int pcnt   = 0;
    int n_vec  = 0;
    int n_err  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
        int         exp_ov;
        int         exp_pe;
    } vec_t;

    vec_t vecs[$];

    uart_rx #(.OVERSAMPLE(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_tick     (baud_tick),
        .rx_serial     (rx_serial),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_parity_err (rx_parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // baud_tick high for one clk out of every four, counted in posedges.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            pcnt = pcnt + 1;
            baud_tick = (pcnt % 4 == 0);
        end
    end

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (rx_overrun === 1'b1) ov_cnt <= ov_cnt + 1;
        if (rx_parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Drive one frame starting on a tick-aligned clock. rdy_off >= 0 pulses rx_ready
    // for exactly one clk at that offset; max_clk truncates the frame.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int rdy_off, input int max_clk);
        logic [10:0] bits;
        int s;
`ifdef UART_RX_PARITY_EN
        bits = {stop, par, d, 1'b0};
`else
        bits = {1'b0, stop, d, 1'b0};
        if (par === 1'bx) bits = 11'd0;
`endif
        while (pcnt % 4 != 0) @(negedge clk);
        s = pcnt;
        for (int t = 0; t < FRAME_CLK && t < max_clk; t++) begin
            rx_serial = bits[t / BIT_CLK];
            if (rdy_off >= 0) rx_ready = (pcnt == s + rdy_off);
            @(negedge clk);
        end
        if (max_clk >= FRAME_CLK) rx_serial = 1'b1;
    endtask

    task automatic check_result(input string tag, input logic ev, input logic [7:0] ed,
                                input int efe, input int eov, input int epe,
                                input int fe0, input int ov0, input int pe0);
        check({tag, " rx_valid"}, rx_valid, ev);
        check({tag, " rx_data"}, rx_data, ed);
        check({tag, " frame_err pulses"}, fe_cnt - fe0, efe);
        check({tag, " overrun pulses"}, ov_cnt - ov0, eov);
        check({tag, " parity_err pulses"}, pe_cnt - pe0, epe);
    endtask

    initial begin
        int fe0, ov0, pe0;
        rst_n     = 1'b0;
        rx_serial = 1'b1;
        rx_ready  = 1'b0;

        // Stimulus table: data, parity bit (even), stop bit, ready level, expectations.
        vecs.push_back('{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 0, 0, 0});
        vecs.push_back('{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1, 0, 0});
        vecs.push_back('{8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 0, 0, 0});
        vecs.push_back('{8'h34, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 0, 1, 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 0, 0, 1});
        vecs.push_back('{8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 0, 0, 0});
        vecs.push_back('{8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1, 0, 1});
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check_result("reset", 1'b0, 8'h00, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0x41 with rx_ready low: byte is delivered and held.
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        send_frame(8'h41, 1'b0, 1'b1, -1, FRAME_CLK);
        repeat (24) @(negedge clk);
        check_result("byte41", 1'b1, 8'h41, 0, 0, 0, fe0, ov0, pe0);
        repeat (50) @(negedge clk);
        check("byte41 held valid", rx_valid, 1'b1);
        check("byte41 held data", rx_data, 8'h41);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("byte41 valid after accept", rx_valid, 1'b0);

        // False start: line low for two ticks only.
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        while (pcnt % 4 != 0) @(negedge clk);
        rx_serial = 1'b0;
        repeat (8) @(negedge clk);
        rx_serial = 1'b1;
        repeat (400) @(negedge clk);
        check_result("false_start", 1'b0, 8'h41, 0, 0, 0, fe0, ov0, pe0);

        // Table-driven frames.
        for (int i = 0; i < vecs.size(); i++) begin
            fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
            rx_ready = vecs[i].rdy;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, -1, FRAME_CLK);
            repeat (24) @(negedge clk);
            rx_ready = 1'b0;
            check_result($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                         vecs[i].exp_fe, vecs[i].exp_ov, vecs[i].exp_pe, fe0, ov0, pe0);
        end

        // Register full, old byte accepted on the very clock the new one completes.
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        send_frame(8'h34, 1'b1, 1'b1, LOAD_OFF - 1, FRAME_CLK);
        rx_ready = 1'b0;
        repeat (24) @(negedge clk);
        check("same_clk_accept rx_valid", rx_valid, 1'b1);
        check("same_clk_accept rx_data", rx_data, 8'h34);
        check("same_clk_accept overrun pulses", ov_cnt - ov0, 0);

        // Reset during data bit 3 of a frame.
        send_frame(8'h3C, 1'b0, 1'b1, -1, 4 * BIT_CLK + 16);
        rst_n = 1'b0;
        #1;
        check_result("midframe_reset", 1'b0, 8'h00, 0, 0, 0, fe_cnt, ov_cnt, pe_cnt);
        repeat (2) @(negedge clk);
        rx_serial = 1'b1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, -1, FRAME_CLK);
        repeat (24) @(negedge clk);
        check_result("after_reset A5", 1'b1, 8'hA5, 0, 0, 0, fe0, ov0, pe0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
